// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the input debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_GLITCH_W        = 8;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// N-flop synchronizer for a single asynchronous bit; nothing sits between stages.
module sync_chain #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_stages;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[N-2:0], i_d};
        end
    end

    assign o_q = r_stages[N-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw input; counts rejected candidate transitions.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GLITCH_W        = DEF_GLITCH_W
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Raw_In,
    output logic                Debounced_Out,
    output logic                Busy,
    output logic [GLITCH_W-1:0] Glitch_Count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_debouncer: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
            $error("input_debouncer: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic             w_sync_q;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_out, w_out_nxt;
    logic             w_glitch;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_d   (Raw_In),
        .o_q   (w_sync_q)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_glitch    = 1'b0;
        unique case (r_state)
            S_LOW: begin
                if (w_sync_q) begin
                    w_state_nxt = S_CHK_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_HIGH: begin
                if (!w_sync_q) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!w_sync_q) begin
                    w_state_nxt = S_CHK_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_LOW: begin
                if (w_sync_q) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_glitch    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Saturating: a rejection at full scale leaves the count unchanged.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != {GLITCH_W{1'b1}})) begin
            r_glitch_cnt <= r_glitch_cnt + 1'b1;
        end
    end

    assign Debounced_Out = r_out;
    assign Busy          = (r_state == S_CHK_HIGH) || (r_state == S_CHK_LOW);
    assign Glitch_Count  = r_glitch_cnt;

endmodule

// File: tb/tb_input_debouncer.sv
// Randomized scoreboard bench for input_debouncer against a run-length reference model.
module tb_input_debouncer;

    localparam int N      = 2;
    localparam int D      = 4;
    localparam int GW     = 8;
    localparam int GMAX   = (1 << GW) - 1;

    logic          Clk;
    logic          Rst;
    logic          Raw_In;
    logic          Debounced_Out;
    logic          Busy;
    logic [GW-1:0] Glitch_Count;

    input_debouncer #(
        .SYNC_STAGES     (N),
        .DEBOUNCE_CYCLES (D),
        .GLITCH_W        (GW)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Raw_In        (Raw_In),
        .Debounced_Out (Debounced_Out),
        .Busy          (Busy),
        .Glitch_Count  (Glitch_Count)
    );

    typedef struct packed {
        logic          out;
        logic          busy;
        logic [GW-1:0] glitch;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: accepted level, length of the current disagreeing run,
    // glitch tally, and a history of captured raw samples.
    int   m_level;
    int   m_run;
    int   m_glitch;
    bit   hist[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_level  = 0;
        m_run    = 0;
        m_glitch = 0;
        hist.delete();
    endtask

    // One clock edge: the synchronized sample is the raw value captured N edges ago.
    task automatic model_edge(input bit raw);
        bit s;
        exp_t e;
        s = (hist.size() >= N) ? hist[N-1] : 1'b0;
        hist.push_front(raw);
        if (hist.size() > N + 2) void'(hist.pop_back());
        if (int'(s) != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = int'(s);
                m_run   = 0;
            end
        end else begin
            if (m_run > 0 && m_glitch < GMAX) m_glitch++;
            m_run = 0;
        end
        e.out    = m_level[0];
        e.busy   = (m_run > 0);
        e.glitch = GW'(m_glitch);
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; drives the input, models the next rising edge.
    task automatic step(input bit raw);
        Raw_In = raw;
        @(posedge Clk);
        model_edge(raw);
        @(negedge Clk);
    endtask

    task automatic hold(input bit raw, input int cycles);
        for (int i = 0; i < cycles; i++) step(raw);
    endtask

    task automatic do_reset(input bit raw, input int cycles);
        #1;
        check("sb_drained_before_reset", sb_q.size(), 0);
        Raw_In = raw;
        #2 Rst = 1'b1;
        #1;
        check("rst_async_out",    Debounced_Out, 0);
        check("rst_async_busy",   Busy,          0);
        check("rst_async_glitch", Glitch_Count,  0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            check("rst_hold_out",    Debounced_Out, 0);
            check("rst_hold_busy",   Busy,          0);
            check("rst_hold_glitch", Glitch_Count,  0);
        end
        Rst = 1'b0;
        model_clear();
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("debounced_out", Debounced_Out, e.out);
                check("busy",          Busy,          e.busy);
                check("glitch_count",  Glitch_Count,  e.glitch);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst    = 1'b1;
        Raw_In = 1'b1;
        model_clear();
        @(negedge Clk);

        // Input held high through reset is treated as a fresh rise afterwards.
        do_reset(1'b1, 3);
        hold(1'b1, 10);

        // Clean fall then clean rise.
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);

        // Pulse-width boundary: 3 cycles rejected, 4 cycles accepted.
        hold(1'b1, 3);
        hold(1'b0, 8);
        hold(1'b1, 4);
        hold(1'b0, 2);
        hold(1'b0, 8);

        // Bounce while high, then settle low.
        hold(1'b1, 10);
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            step(1'b0);
        end
        hold(1'b0, 10);

        // Drive the glitch counter into saturation.
        for (int i = 0; i < 300; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 3);
        end

        // Reset mid-qualification: four high edges leave the check count at 2.
        hold(1'b0, 4);
        hold(1'b1, 4);
        do_reset(1'b0, 2);
        hold(1'b0, 6);

        // Randomized bursts of varying length and level.
        for (int i = 0; i < 120; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
        end
        do_reset(1'($urandom_range(0, 1)), 1);
        for (int i = 0; i < 60; i++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
        end

        #1;
        check("sb_drained_at_end", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
